// File: rtl/rw_sync_pkg.sv
// Shared constants and helpers for the clock-domain synchronizer blocks.
package rw_sync_pkg;

    // Shallowest synchronizer chain considered metastability-safe.
    localparam int SYNC_STAGES_MIN = 2;

    // Largest value a w-bit saturating counter can hold.
    function automatic int PEND_MAX(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pulse_synch_hs_if.sv
// Event-strobe bundle crossing from genClk to synClk.
// The ovf/ovfClr pair exists only when RW_PULSE_SYNCH_OVF_EN is defined.
interface pulse_synch_hs_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] dataIn;
    logic [NCH-1:0] dataOut;
    logic [NCH-1:0] busy;
`ifdef RW_PULSE_SYNCH_OVF_EN
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] ovfClr;

    modport master (output dataIn, output ovfClr, input dataOut, input busy, input ovf);
    modport slave  (input dataIn, input ovfClr, output dataOut, output busy, output ovf);
`else
    modport master (output dataIn, input dataOut, input busy);
    modport slave  (input dataIn, output dataOut, output busy);
`endif
endinterface

// File: rtl/pulse_synch_hs_sync_chain.sv
// 1-bit synchronizer: STAGES flops in series, cleared asynchronously.
module sync_chain
    import rw_sync_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic hardReset_n,
    input  logic d,
    output logic q
);

    if (STAGES < SYNC_STAGES_MIN) begin : g_depth_chk
        $error("sync_chain: STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the chain; the last flop is the safe copy.
    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pulse_synch_hs.sv
// Multi-channel handshaked pulse synchronizer (genClk -> synClk).
// Each channel turns dataIn pulses into a req toggle, returns it as an ack,
// and queues pulses that arrive while a crossing is in flight.
// Optional build macro: RW_PULSE_SYNCH_OVF_EN adds sticky per-channel overflow flags.
module pulse_synch_hs
    import rw_sync_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 2
) (
    input  logic             genClk,
    input  logic             hardReset_n,
    input  logic             synClk,
    pulse_synch_hs_if.slave  bus
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(PEND_MAX(PEND_W));

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_stage_chk
        $error("pulse_synch_hs: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic [NCH-1:0] data_out;
    logic [NCH-1:0] busy;
`ifdef RW_PULSE_SYNCH_OVF_EN
    logic [NCH-1:0] ovf;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic              req;
        logic              req_s;
        logic              req_h;
        logic              ack_s;
        logic              idle;
        logic              launch;
        logic [PEND_W-1:0] cnt;
        logic [PEND_W-1:0] cnt_nxt;

        // A new crossing may start only once the previous toggle has come back.
        assign idle   = (req == ack_s);
        assign launch = idle & ((cnt != '0) | bus.dataIn[i]);

        // Pending count: a pulse that cannot launch is queued (saturating),
        // a launch without a new pulse drains one; launch-with-pulse leaves it as is.
        always_comb begin
            cnt_nxt = cnt;
            if (bus.dataIn[i] && !launch && (cnt != CNT_MAX)) begin
                cnt_nxt = cnt + 1'b1;
            end else if (!bus.dataIn[i] && launch) begin
                cnt_nxt = cnt - 1'b1;
            end
        end

        // genClk side state: request toggle and pending counter.
        always_ff @(posedge genClk or negedge hardReset_n) begin
            if (!hardReset_n) begin
                req <= 1'b0;
                cnt <= '0;
            end else begin
                req <= req ^ launch;
                cnt <= cnt_nxt;
            end
        end

        sync_chain #(.STAGES(SYNC_STAGES)) u_fwd (
            .clk         (synClk),
            .hardReset_n (hardReset_n),
            .d           (req),
            .q           (req_s)
        );

        sync_chain #(.STAGES(SYNC_STAGES)) u_ret (
            .clk         (genClk),
            .hardReset_n (hardReset_n),
            .d           (req_s),
            .q           (ack_s)
        );

        // History of the synchronized request; an edge on req_s becomes one output cycle.
        always_ff @(posedge synClk or negedge hardReset_n) begin
            if (!hardReset_n) begin
                req_h <= 1'b0;
            end else begin
                req_h <= req_s;
            end
        end

        assign data_out[i] = req_s ^ req_h;
        assign busy[i]     = !idle | (cnt != '0);

`ifdef RW_PULSE_SYNCH_OVF_EN
        logic drop;
        logic ovf_r;

        assign drop = bus.dataIn[i] & !launch & (cnt == CNT_MAX);

        // Sticky overflow: a drop sets it and takes priority over a clear.
        always_ff @(posedge genClk or negedge hardReset_n) begin
            if (!hardReset_n) begin
                ovf_r <= 1'b0;
            end else if (drop) begin
                ovf_r <= 1'b1;
            end else if (bus.ovfClr[i]) begin
                ovf_r <= 1'b0;
            end
        end

        assign ovf[i] = ovf_r;
`endif
    end

    assign bus.dataOut = data_out;
    assign bus.busy    = busy;
`ifdef RW_PULSE_SYNCH_OVF_EN
    assign bus.ovf     = ovf;
`endif

endmodule

// File: tb/tb_pulse_synch_hs.sv
// Directed bench for pulse_synch_hs; overflow checks follow RW_PULSE_SYNCH_OVF_EN.
`timescale 1ns/100ps
module tb_pulse_synch_hs;

    localparam int NCH         = 4;
    localparam int SYNC_STAGES = 2;
    localparam int PEND_W      = 2;

    logic    genClk      = 1'b0;
    logic    synClk      = 1'b0;
    logic    hardReset_n = 1'b0;
    realtime gen_half    = 5.0;
    realtime syn_half    = 12.5;

    always #(gen_half) genClk = ~genClk;
    always #(syn_half) synClk = ~synClk;

    pulse_synch_hs_if #(.NCH(NCH)) bus ();

    pulse_synch_hs #(
        .NCH         (NCH),
        .SYNC_STAGES (SYNC_STAGES),
        .PEND_W      (PEND_W)
    ) dut (
        .genClk      (genClk),
        .hardReset_n (hardReset_n),
        .synClk      (synClk),
        .bus         (bus)
    );

    int             total = 0;
    int             bad   = 0;
    int             pulses [NCH] = '{default: 0};
    int             base   [NCH] = '{default: 0};
    int             wide  = 0;
    logic [NCH-1:0] prev_do = '0;

    // Output monitor: count dataOut cycles per channel, flag any two-cycle-wide pulse.
    always @(negedge synClk) begin
        for (int i = 0; i < NCH; i++) begin
            if (bus.dataOut[i] === 1'b1) pulses[i] = pulses[i] + 1;
        end
        if ((bus.dataOut & prev_do) != '0) wide = wide + 1;
        prev_do = bus.dataOut;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < NCH; i++) base[i] = pulses[i];
    endtask

    // exp holds one 4-bit expected pulse count per channel, ch0 in the low nibble.
    task automatic check_counts(input string tag, input logic [15:0] exp);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("%s_ch%0d", tag, i), 32'(pulses[i] - base[i]), 32'(exp[4*i +: 4]));
        end
    endtask

    task automatic burst(input logic [NCH-1:0] m, input int n);
        @(negedge genClk);
        bus.dataIn = m;
        repeat (n) @(negedge genClk);
        bus.dataIn = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.busy !== '0 && n < budget) begin
            @(negedge genClk);
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'h0);
        repeat (4) @(negedge genClk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.dataIn = '0;
`ifdef RW_PULSE_SYNCH_OVF_EN
        bus.ovfClr = '0;
`endif

        // Reset held with random activity on dataIn.
        repeat (8) begin
            @(negedge genClk);
            bus.dataIn = NCH'($urandom);
        end
        check("rst_dataOut", 32'(bus.dataOut), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
`ifdef RW_PULSE_SYNCH_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'h0);
`endif
        bus.dataIn = '0;
        @(negedge genClk);
        hardReset_n = 1'b1;
        repeat (10) @(negedge genClk);
        check_counts("rst_quiet", 16'h0000);
        snap();
        burst(4'b0001, 1);
        wait_idle("first", 200);
        check_counts("first", 16'h0001);

        // Single pulse on ch2, genClk 100 MHz / synClk 40 MHz.
        snap();
        @(negedge genClk);
        bus.dataIn = 4'b0100;
        @(posedge genClk);
        #1;
        bus.dataIn = '0;
        check("single_busy", 32'(bus.busy), 32'h4);
        n = 0;
        do begin
            @(posedge synClk);
            #1;
            n++;
        end while (bus.dataOut[2] !== 1'b1 && n < 20);
        check("single_lat_2to3", 32'(n >= 2 && n <= 3), 32'h1);
        check("single_dataOut", 32'(bus.dataOut), 32'h4);
        check("single_busy_held", 32'(bus.busy), 32'h4);
        @(posedge synClk);
        #1;
        check("single_one_cycle", 32'(bus.dataOut), 32'h0);
        wait_idle("single", 200);
        check_counts("single", 16'h0100);

        // Bursts on ch0 with synClk 20 MHz so the round trip spans many genClk cycles.
        syn_half = 25.0;
        repeat (10) @(negedge genClk);
        snap();
        burst(4'b0001, 4);
        wait_idle("burst4", 400);
        check_counts("burst4", 16'h0004);
`ifdef RW_PULSE_SYNCH_OVF_EN
        check("burst4_ovf", 32'(bus.ovf), 32'h0);
`endif

        snap();
        burst(4'b0001, 6);
        wait_idle("burst6", 400);
        check_counts("burst6", 16'h0004);
`ifdef RW_PULSE_SYNCH_OVF_EN
        check("burst6_ovf_set", 32'(bus.ovf), 32'h1);
        @(negedge genClk);
        bus.ovfClr = 4'b0001;
        @(negedge genClk);
        bus.ovfClr = '0;
        check("ovf_cleared", 32'(bus.ovf), 32'h0);
`endif

        snap();
        @(negedge genClk);
        bus.dataIn = 4'b0001;
        repeat (5) @(negedge genClk);
`ifdef RW_PULSE_SYNCH_OVF_EN
        bus.ovfClr = 4'b0001;
`endif
        @(negedge genClk);
        bus.dataIn = '0;
`ifdef RW_PULSE_SYNCH_OVF_EN
        bus.ovfClr = '0;
        check("ovf_set_wins", 32'(bus.ovf), 32'h1);
`endif
        wait_idle("burst6b", 400);
        check_counts("burst6b", 16'h0004);
`ifdef RW_PULSE_SYNCH_OVF_EN
        @(negedge genClk);
        bus.ovfClr = 4'b0001;
        @(negedge genClk);
        bus.ovfClr = '0;
        check("ovf_final_clr", 32'(bus.ovf), 32'h0);
`endif

        // All channels at once, genClk 20 MHz / synClk 250 MHz.
        gen_half = 25.0;
        syn_half = 2.0;
        repeat (5) @(negedge genClk);
        snap();
        burst(4'b1111, 1);
        wait_idle("allch", 200);
        check_counts("allch", 16'h1111);
        check("allch_width", 32'(wide), 32'h0);

        // Reset while ch1 has two pending pulses and a toggle in flight.
        gen_half = 5.0;
        syn_half = 12.5;
        repeat (10) @(negedge genClk);
        snap();
        @(negedge genClk);
        bus.dataIn = 4'b0010;
        repeat (3) @(posedge genClk);
        #1;
        check("midrst_busy_before", 32'(bus.busy), 32'h2);
        hardReset_n = 1'b0;
        bus.dataIn  = '0;
        repeat (5) @(negedge genClk);
        check("midrst_busy_in_rst", 32'(bus.busy), 32'h0);
        check("midrst_dataOut_in_rst", 32'(bus.dataOut), 32'h0);
        hardReset_n = 1'b1;
        repeat (60) @(negedge genClk);
        check_counts("midrst", 16'h0000);
        check("midrst_busy_after", 32'(bus.busy), 32'h0);
        snap();
        burst(4'b0010, 1);
        wait_idle("postrst", 200);
        check_counts("postrst", 16'h0010);
        check("final_width", 32'(wide), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
